// File: rtl/io64_uart_tx_pkg.sv
// Shared IO definitions for the IO64 UART transmitter: port addresses, IO65 status bit positions,
// and transmitter FSM state encodings.
package io64_uart_tx_pkg;

  localparam logic [7:0] IO64_ADDR = 8'd64;
  localparam logic [7:0] IO65_ADDR = 8'd65;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/io64_uart_tx_fifo.sv
// Synchronous DEPTH x W word FIFO. Full/empty/count reflect the pre-edge state; a push while full
// or a pop while empty is ignored. Pointers wrap modulo DEPTH, which must be a power of two.
module io64_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_dat = mem[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/io64_uart_tx.sv
// Queues CPU stores to IO64 and sends each 16-bit word on a UART line, low byte first, LSB first.
// Define IO64_PARITY_EN to insert an even-parity bit after the data bits (8E1 instead of 8N1).
module io64_uart_tx
  import io64_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4,
  parameter int AW           = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IO64_OUT,
  input  logic        IO64_WE,
  input  logic        STATUS_CLR,
  output logic        TX,
  output logic        TX_BUSY,
  output logic        FIFO_FULL,
  output logic [15:0] IO65_STATUS
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          byte_sel_q, byte_sel_d;
  logic [15:0]   word_q, word_d;
  logic          ovf_q, ovf_d;
  logic          tx_q, tx_d;

  logic          bit_done;
  logic [7:0]    cur_byte_d;
  logic          fifo_pop;
  logic [15:0]   fifo_dat;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_cnt;

  io64_uart_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (16)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .push     (IO64_WE),
    .push_dat (IO64_OUT),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_sel_q <= 1'b0;
      word_q     <= '0;
      ovf_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_sel_q <= byte_sel_d;
      word_q     <= word_d;
      ovf_q      <= ovf_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_sel_d = byte_sel_q;
    word_d     = word_q;
    fifo_pop   = 1'b0;
    bit_done   = (timer_q == T_LAST);
    if (state_q != S_IDLE) timer_d = bit_done ? '0 : timer_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_dat;
          byte_sel_d = 1'b0;
          timer_d    = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef IO64_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef IO64_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          // The high byte follows the low byte back-to-back; a word boundary costs one idle cycle.
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = S_START;
          end else begin
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The full check uses the pre-edge count, so a same-edge pop does not rescue the word.
    ovf_d = ovf_q;
    if (STATUS_CLR) ovf_d = 1'b0;
    if (IO64_WE && fifo_full) ovf_d = 1'b1;
  end

  // TX is computed from next-state values so the registered line changes on the same edge as the FSM.
  always_comb begin
    cur_byte_d = byte_sel_d ? word_d[15:8] : word_d[7:0];
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte_d[bit_idx_d];
`ifdef IO64_PARITY_EN
      S_PARITY: tx_d = ^cur_byte_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    IO65_STATUS                          = '0;
    IO65_STATUS[ST_FULL]                 = fifo_full;
    IO65_STATUS[ST_EMPTY]                = fifo_empty;
    IO65_STATUS[ST_OVF]                  = ovf_q;
    IO65_STATUS[ST_BUSY]                 = (state_q != S_IDLE);
    IO65_STATUS[ST_CNT_LSB +: AW+1]      = fifo_cnt;
  end

  assign TX        = tx_q;
  assign TX_BUSY   = (state_q != S_IDLE);
  assign FIFO_FULL = fifo_full;

endmodule

// File: tb/tb_io64_uart_tx.sv
// Directed bench for io64_uart_tx with CLKS_PER_BIT=4, DEPTH=4; a background receiver decodes TX frames.
module tb_io64_uart_tx;

  localparam int CPB = 4;
`ifdef IO64_PARITY_EN
  localparam bit PAR      = 1'b1;
  localparam int FB       = 11;
  localparam int WORD_CYC = 88;
`else
  localparam bit PAR      = 1'b0;
  localparam int FB       = 10;
  localparam int WORD_CYC = 80;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] io64_out = '0;
  logic        io64_we = 1'b0;
  logic        status_clr = 1'b0;
  logic        tx, tx_busy, fifo_full;
  logic [15:0] io65_status;

  int n_pass  = 0;
  int n_total = 0;
  logic [10:0] rx_q[$];

  io64_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (4),
    .AW           (2)
  ) dut (
    .CLK         (clk),
    .RESET       (reset),
    .IO64_OUT    (io64_out),
    .IO64_WE     (io64_we),
    .STATUS_CLR  (status_clr),
    .TX          (tx),
    .TX_BUSY     (tx_busy),
    .FIFO_FULL   (fifo_full),
    .IO65_STATUS (io65_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame layout: bit0 start, bits 8:1 data, then parity (if enabled) and stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = '0;
    f[8:1] = b;
    if (PAR) begin
      f[9]  = ^b;
      f[10] = 1'b1;
    end else begin
      f[9]  = 1'b1;
    end
    return f;
  endfunction

  task automatic pop_frame(output logic [10:0] f);
    if (rx_q.size() > 0) f = rx_q.pop_front();
    else f = '1;
  endtask

  task automatic push_word(input logic [15:0] w);
    io64_out = w;
    io64_we  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io64_we  = 1'b0;
  endtask

  task automatic wait_idle_empty(input string tag);
    for (int c = 0; c < 700 && io65_status !== 16'h0006; c++) @(negedge clk);
    check(tag, io65_status, 16'h0006);
  endtask

  // Single word from idle: start-bit latency, busy duration and both decoded frames.
  task automatic send_timed(input logic [15:0] w, output logic [10:0] lo, output logic [10:0] hi);
    int n_busy;
    rx_q.delete();
    push_word(w);
    check("push_tx_still_idle", tx, 1'b1);
    check("push_status_cnt1", io65_status, 16'h0010);
    @(negedge clk);
    check("start_bit_after_k1", tx, 1'b0);
    check("start_status_busy", io65_status, 16'h000A);
    n_busy = 1;
    for (int c = 0; c < 300 && tx_busy; c++) begin
      @(negedge clk);
      if (tx_busy) n_busy++;
    end
    check("busy_cycles", n_busy, WORD_CYC);
    repeat (4) @(negedge clk);
    check("rx_frame_count", rx_q.size(), 2);
    pop_frame(lo);
    pop_frame(hi);
    check("rx_low_frame", lo, frame_of(w[7:0]));
    check("rx_high_frame", hi, frame_of(w[15:8]));
  endtask

  // Background UART receiver: samples mid-bit; frames interrupted by a drop of TX_BUSY are discarded.
  initial begin
    logic [10:0] bits;
    bit ok;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && tx_busy === 1'b1) begin
        bits = '0;
        ok   = 1'b1;
        repeat (CPB/2) begin
          @(negedge clk);
          if (tx_busy !== 1'b1) ok = 1'b0;
        end
        bits[0] = tx;
        for (int i = 1; i < FB; i++) begin
          repeat (CPB) begin
            @(negedge clk);
            if (tx_busy !== 1'b1) ok = 1'b0;
          end
          bits[i] = tx;
        end
        if (ok) rx_q.push_back(bits);
      end
    end
  end

  initial begin
    logic [10:0] lo, hi;
    int n_bad;

    // Reset
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_status", io65_status, 16'h0002);
    reset = 1'b0;
    @(negedge clk);

    // One word 0x1234
    send_timed(16'h1234, lo, hi);
    check("w1234_low_data", lo[8:1], 8'h34);
    check("w1234_high_data", hi[8:1], 8'h12);
    check("w1234_low_stop", lo[FB-1], 1'b1);
    repeat (3) @(negedge clk);

    // Six consecutive pushes: the sixth overflows
    rx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      io64_out = 16'(i);
      io64_we  = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    io64_we = 1'b0;
    check("ovf_status", io65_status, 16'h004D);
    check("ovf_full", fifo_full, 1'b1);
    check("ovf_bit2", io65_status[2], 1'b1);
    wait_idle_empty("ovf_drain");
    repeat (3) @(negedge clk);
    check("ovf_rx_count", rx_q.size(), 10);
    for (int i = 1; i <= 5; i++) begin
      pop_frame(lo);
      pop_frame(hi);
      check($sformatf("ovf_word%0d_lo", i), lo, frame_of(8'(i)));
      check($sformatf("ovf_word%0d_hi", i), hi, frame_of(8'h00));
    end

    // STATUS_CLR alone, then STATUS_CLR together with an overflowing push
    status_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    status_clr = 1'b0;
    check("clr_alone", io65_status, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      io64_out = 16'hA0 + 16'(i);
      io64_we  = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("clr_full_no_ovf", io65_status, 16'h0049);
    io64_out   = 16'h00AF;
    io64_we    = 1'b1;
    status_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io64_we    = 1'b0;
    status_clr = 1'b0;
    check("clr_vs_ovf_set_wins", io65_status, 16'h004D);
    wait_idle_empty("clr_drain");
    status_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    status_clr = 1'b0;
    check("clr_after_drain", io65_status, 16'h0002);
    repeat (3 * FB * CPB) @(negedge clk);

    // Reset during DATA bit 3 of the low byte, with a second word queued
    rx_q.delete();
    io64_out = 16'h1234;
    io64_we  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io64_out = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    io64_we = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("midrst_bit3_before", tx, 1'b0);
    check("midrst_status_before", io65_status, 16'h0018);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_status", io65_status, 16'h0002);
    n_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) n_bad++;
    end
    check("midrst_quiet", n_bad, 0);
    check("midrst_no_frames", rx_q.size(), 0);

`ifdef IO64_PARITY_EN
    // Parity frames for 0x0734
    send_timed(16'h0734, lo, hi);
    check("par_low_bit", lo[9], 1'b1);
    check("par_high_bit", hi[9], 1'b1);
    check("par_high_data", hi[8:1], 8'h07);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
